// File: rtl/rr_shift_priority_arb.sv
// Round-robin arbiter with a registered grant slot and valid/ready handshake.
// The pick scans the request vector starting at a rotating pointer; accepted
// grants advance the pointer past the winner so every requester gets a turn.
module rr_shift_priority_arb #(
    parameter int N     = 64,
    parameter int PTR_W = $clog2(N),
    parameter int RR_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     valid_array_i,
    input  logic             ptr_ld_i,
    input  logic [PTR_W-1:0] ptr_ld_val_i,
    input  logic             grant_ready_i,
    output logic             grant_valid_o,
    output logic [PTR_W-1:0] grant_ptr_o,
    output logic [N-1:0]     grant_onehot_o,
    output logic [PTR_W-1:0] bottom_ptr_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_grant_ptr;
    logic [PTR_W-1:0] r_bottom_ptr;

    logic             w_fire;
    logic             w_load;
    logic [N-1:0]     w_grant_onehot;
    logic [N-1:0]     w_req_eff;
    logic [2*N-1:0]   w_req_dbl;
    logic [N-1:0]     w_req_rot;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_eff;
    logic [PTR_W-1:0] w_pick_off;
    logic [PTR_W-1:0] w_pick_idx;
    logic             w_pick_vld;

    assign w_fire         = (r_state == ST_FULL) && grant_ready_i;
    assign w_grant_onehot = (r_state == ST_FULL) ? (N'(1) << r_grant_ptr) : '0;
    assign w_ptr_inc      = r_grant_ptr + PTR_W'(1);

    // The index being accepted this cycle is masked so it cannot win again
    // immediately; the scan base jumps past it when rotation is enabled.
    assign w_req_eff = valid_array_i & ~(w_fire ? w_grant_onehot : '0);
    assign w_ptr_eff = (w_fire && (RR_EN != 0)) ? w_ptr_inc : r_bottom_ptr;

    // Rotating the doubled vector puts the scan base at bit 0, so the first
    // set bit of the low half is the winner's distance from the base.
    assign w_req_dbl  = {w_req_eff, w_req_eff} >> w_ptr_eff;
    assign w_req_rot  = w_req_dbl[N-1:0];
    assign w_pick_idx = w_ptr_eff + w_pick_off;

    // Priority encoder: lowest set bit of the rotated request vector.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_vld = 1'b1;
                w_pick_off = PTR_W'(k);
            end
        end
    end

    // Next-state and slot-load decision; a full slot only changes on accept.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_fire) begin
                    if (w_pick_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant slot: captures the winner when the slot is loaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant_ptr <= '0;
        end else if (w_load) begin
            r_grant_ptr <= w_pick_idx;
        end
    end

    // Bottom pointer: an explicit load beats the round-robin advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bottom_ptr <= '0;
        end else if (ptr_ld_i) begin
            r_bottom_ptr <= ptr_ld_val_i;
        end else if (w_fire && (RR_EN != 0)) begin
            r_bottom_ptr <= w_ptr_inc;
        end
    end

    assign grant_valid_o  = (r_state == ST_FULL);
    assign grant_ptr_o    = r_grant_ptr;
    assign grant_onehot_o = w_grant_onehot;
    assign bottom_ptr_o   = r_bottom_ptr;

endmodule
